// File: rtl/pwm_pkg.sv
// Shared definitions for the PWM ramp controller: datapath width, clock rate, FSM encoding
// and the command clamp helper.
package pwm_pkg;

  localparam int unsigned PWM_CW = 13;
  localparam int unsigned CLK_HZ = 50_000_000;

  localparam logic ST_IDLE = 1'b0;
  localparam logic ST_RAMP = 1'b1;

  typedef enum logic {
    StIdle = ST_IDLE,
    StRamp = ST_RAMP
  } ramp_state_e;

  // Saturate a requested duty to the period length so the comparator never sees > PERIOD.
  function automatic logic [PWM_CW-1:0] clamp_duty(input logic [PWM_CW-1:0] duty,
                                                    input logic [PWM_CW-1:0] limit);
    return (duty > limit) ? limit : duty;
  endfunction

endpackage

// File: rtl/pwm_core.sv
// Period counter, comparator and registered PWM output. The duty input is the value that
// will be in force on the next cycle, so pwm stays cycle-aligned with counter.
module pwm_core
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = 5000,
  parameter int unsigned CW     = PWM_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic [CW-1:0] duty,
  output logic [CW-1:0] counter,
  output logic          period_tick,
  output logic          pwm
);

  localparam logic [CW-1:0] LastCount = CW'(PERIOD - 1);

  logic [CW-1:0] counter_q, counter_d;
  logic          pwm_q, pwm_d;

  always_comb begin
    counter_d = '0;
    if (en && (counter_q != LastCount)) begin
      counter_d = counter_q + CW'(1);
    end
    pwm_d = en & (counter_d < duty);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      counter_q <= '0;
      pwm_q     <= 1'b0;
    end else begin
      counter_q <= counter_d;
      pwm_q     <= pwm_d;
    end
  end

  assign counter     = counter_q;
  assign period_tick = en & (counter_q == LastCount);
  assign pwm         = pwm_q;

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// Duty-command sequencer: accepts a target over valid/ready and slews the live duty toward it
// by at most STEP counts per PWM period, updating only on period boundaries.
module pwm_ramp_ctrl
  import pwm_pkg::*;
#(
  parameter int unsigned PERIOD = 5000,
  parameter int unsigned STEP   = 50,
  parameter int unsigned CW     = PWM_CW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [CW-1:0] cmd_duty,
  output logic          pwm,
  output logic [CW-1:0] counter,
  output logic [CW-1:0] duty_cur,
  output logic          period_tick,
  output logic          busy
);

  localparam logic [CW-1:0] PeriodC = CW'(PERIOD);
  localparam logic [CW:0]   StepC   = (CW + 1)'(STEP);

  ramp_state_e   state_q, state_d;
  logic [CW-1:0] duty_q, duty_d;
  logic [CW-1:0] target_q, target_d;
  logic [CW-1:0] cmd_clamped;
  logic [CW:0]   diff_up, diff_dn;
  logic          accept;

  always_comb begin
    cmd_ready   = (state_q == StIdle) & ~rst;
    accept      = cmd_valid & cmd_ready;
    cmd_clamped = clamp_duty(cmd_duty, PeriodC);
    // One extra bit keeps the distance-to-target compare free of wrap-around.
    diff_up     = {1'b0, target_q} - {1'b0, duty_q};
    diff_dn     = {1'b0, duty_q} - {1'b0, target_q};
    state_d     = state_q;
    duty_d      = duty_q;
    target_d    = target_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          target_d = cmd_clamped;
          if (cmd_clamped != duty_q) begin
            state_d = StRamp;
          end
        end
      end
      StRamp: begin
        if (period_tick) begin
          if (target_q > duty_q) begin
            duty_d = (diff_up <= StepC) ? target_q : duty_q + StepC[CW-1:0];
          end else begin
            duty_d = (diff_dn <= StepC) ? target_q : duty_q - StepC[CW-1:0];
          end
          if (duty_d == target_q) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      duty_q   <= '0;
      target_q <= '0;
    end else begin
      state_q  <= state_d;
      duty_q   <= duty_d;
      target_q <= target_d;
    end
  end

  pwm_core #(
    .PERIOD (PERIOD),
    .CW     (CW)
  ) u_core (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .duty        (duty_d),
    .counter     (counter),
    .period_tick (period_tick),
    .pwm         (pwm)
  );

  assign duty_cur = duty_q;
  assign busy     = (state_q == StRamp);

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// Self-checking bench for pwm_ramp_ctrl: table of ramp commands plus hand-written sequences
// for enable freeze and mid-ramp reset, with expected per-period duty held in a scoreboard.
module tb_pwm_ramp_ctrl;

  localparam int PERIOD = 100;
  localparam int STEP   = 10;
  localparam int CW     = 13;

  logic          clk = 1'b0;
  logic          rst, en, cmd_valid, cmd_ready, pwm, period_tick, busy;
  logic [CW-1:0] cmd_duty, counter, duty_cur;

  pwm_ramp_ctrl #(
    .PERIOD (PERIOD),
    .STEP   (STEP)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .en          (en),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_duty    (cmd_duty),
    .pwm         (pwm),
    .counter     (counter),
    .duty_cur    (duty_cur),
    .period_tick (period_tick),
    .busy        (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    int duty;
    bit busy;
  } sb_t;

  typedef struct {
    logic [CW-1:0] cmd;
    int            tgt;
    bit            pulse;
  } vec_t;

  sb_t  exp_q[$];
  vec_t vecs[4];
  int   n_vec = 0;
  int   n_err = 0;
  int   model_duty = 0;
  int   prev_duty = 0;
  int   hi_init = 0;
  bit   full = 1'b0;

  function automatic int step_toward(input int d, input int t);
    if (t > d) return (d + STEP >= t) ? t : d + STEP;
    return (d - STEP <= t) ? t : d - STEP;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Advance on negedges until period_tick, counting pwm-high cycles from hi_init.
  task automatic wait_tick(output int highs);
    bit seen;
    seen  = 1'b0;
    highs = hi_init;
    for (int i = 0; i < 3 * PERIOD && !seen; i++) begin
      @(negedge clk);
      cmd_valid = 1'b0;
      if (pwm) highs++;
      seen = period_tick;
    end
    check("tick_seen", seen, 1);
  endtask

  task automatic start_cmd(input logic [CW-1:0] cmd, input int tgt);
    int d;
    check("cmd_ready_idle", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_duty  = cmd;
    d = model_duty;
    while (d != tgt) begin
      d = step_toward(d, tgt);
      exp_q.push_back('{duty: d, busy: (d != tgt)});
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    check("busy_after_accept", busy, (tgt != model_duty) ? 1 : 0);
    hi_init   = 0;
    full      = 1'b0;
    prev_duty = model_duty;
  endtask

  task automatic drain(input int max_ticks, input bit pulse);
    int  highs;
    int  n;
    sb_t e;
    n = 0;
    while (exp_q.size() > 0 && (max_ticks < 0 || n < max_ticks)) begin
      wait_tick(highs);
      if (full) check("pwm_high_cycles", highs, prev_duty);
      @(negedge clk);
      e = exp_q.pop_front();
      check("duty_cur", duty_cur, e.duty);
      check("busy", busy, e.busy ? 1 : 0);
      hi_init    = pwm ? 1 : 0;
      prev_duty  = e.duty;
      model_duty = e.duty;
      full       = 1'b1;
      n++;
      if (pulse && n == 1) begin
        cmd_valid = 1'b1;
        cmd_duty  = 13'd77;
        check("cmd_ready_in_ramp", cmd_ready, 0);
      end
    end
  endtask

  task automatic final_period();
    int highs;
    wait_tick(highs);
    check("final_period_high_cycles", highs, model_duty);
    @(negedge clk);
    check("duty_hold", duty_cur, model_duty);
    check("busy_idle", busy, 0);
    hi_init   = pwm ? 1 : 0;
    prev_duty = model_duty;
    full      = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int ticks_seen;
    vecs[0] = '{cmd: 13'd25,   tgt: 25,  pulse: 1'b0};
    vecs[1] = '{cmd: 13'd0,    tgt: 0,   pulse: 1'b1};
    vecs[2] = '{cmd: 13'd8000, tgt: 100, pulse: 1'b0};
    vecs[3] = '{cmd: 13'd0,    tgt: 0,   pulse: 1'b0};

    rst       = 1'b1;
    en        = 1'b1;
    cmd_valid = 1'b0;
    cmd_duty  = '0;

    // Reset held for three rising edges.
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("rst_pwm", pwm, 0);
      check("rst_counter", counter, 0);
      check("rst_busy", busy, 0);
      check("rst_cmd_ready", cmd_ready, 0);
    end
    rst = 1'b0;
    @(negedge clk);
    check("cmd_ready_after_rst", cmd_ready, 1);
    check("counter_after_rst", counter, 1);

    // Ramp up, ramp down with ignored mid-ramp command, clamped full-scale, back to zero.
    for (int i = 0; i < 4; i++) begin
      start_cmd(vecs[i].cmd, vecs[i].tgt);
      drain(-1, vecs[i].pulse);
      final_period();
    end

    // Enable dropped for 250 cycles mid-ramp at duty 20.
    start_cmd(13'd50, 50);
    drain(2, 1'b0);
    en = 1'b0;
    ticks_seen = 0;
    for (int i = 0; i < 250; i++) begin
      @(negedge clk);
      if (period_tick) ticks_seen++;
      if (i == 1 || i == 249) begin
        check("dis_counter", counter, 0);
        check("dis_pwm", pwm, 0);
        check("dis_duty_frozen", duty_cur, 20);
        check("dis_busy", busy, 1);
      end
    end
    check("dis_no_ticks", ticks_seen, 0);
    en      = 1'b1;
    full    = 1'b0;
    hi_init = 0;
    drain(-1, 1'b0);
    final_period();

    // Reset mid-ramp at counter 57, then a fresh one-step command.
    start_cmd(13'd90, 90);
    drain(1, 1'b0);
    repeat (57) @(negedge clk);
    check("counter_before_rst", counter, 57);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_counter", counter, 0);
    check("mid_rst_duty", duty_cur, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_pwm", pwm, 0);
    rst = 1'b0;
    exp_q.delete();
    model_duty = 0;
    @(negedge clk);
    start_cmd(13'd10, 10);
    drain(-1, 1'b0);
    final_period();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
